// File: rtl/rtc_pkg.sv
// Shared RTC definitions: bus FSM states,
// register addresses and default cycle timing.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_GAP
  } rtc_state_e;

  localparam logic [7:0] RTC_ADDR_SEC  = 8'h21;
  localparam logic [7:0] RTC_ADDR_MIN  = 8'h22;
  localparam logic [7:0] RTC_ADDR_HOUR = 8'h23;

  localparam int T_SETUP_DEF = 2;
  localparam int T_PULSE_DEF = 8;
  localparam int T_HOLD_DEF  = 2;
  localparam int T_GAP_DEF   = 4;

  function automatic int max4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Request side and RTC pad side of the bus
// engine, bundled for the requester and engine.
interface rtc_bus_ctrl_if;

  logic       start;
  logic       RW;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       a_d;

  modport master (
    output start, RW, addr, wdata, ad_in,
    input  busy, done, rdata,
    input  ad_out, ad_oe, cs_n,
    input  wr_n, rd_n, a_d
  );

  modport slave (
    input  start, RW, addr, wdata, ad_in,
    output busy, done, rdata,
    output ad_out, ad_oe, cs_n,
    output wr_n, rd_n, a_d
  );

endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase;
// expire is high on the last cycle of the phase.
module rtc_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  // load on phase entry, then count to zero and stay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Two-phase (address, then data) bus cycle
// engine for the external RTC mux bus.
module rtc_bus_ctrl
  import rtc_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_PULSE = T_PULSE_DEF,
  parameter int T_HOLD  = T_HOLD_DEF,
  parameter int T_GAP   = T_GAP_DEF
) (
  input  logic           clk,
  input  logic           Reset_n,
  rtc_bus_ctrl_if.slave  bus
);

  localparam int TMAX =
    max4(T_SETUP, T_PULSE, T_HOLD, T_GAP);
  localparam int CW = $clog2(TMAX + 1);

  localparam logic [CW-1:0] LD_SETUP =
    CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE =
    CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD =
    CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_GAP =
    CW'(T_GAP - 1);

  rtc_state_e r_state;
  rtc_state_e w_next;

  logic          w_load;
  logic [CW-1:0] w_val;
  logic          w_expire;
  logic          w_accept;
  logic          r_entered;

  logic       r_rw;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_cap;

  logic       w_aph;
  logic       w_dph;
  logic       w_cs_n;
  logic       w_wr_n;
  logic       w_rd_n;
  logic       w_a_d;
  logic       w_ad_oe;
  logic [7:0] w_ad_out;
  logic       w_busy;
  logic       w_done;

  logic       r_cs_n;
  logic       r_wr_n;
  logic       r_rd_n;
  logic       r_a_d;
  logic       r_ad_oe;
  logic [7:0] r_ad_out;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_rdata;

  rtc_phase_timer #(
    .W (CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (Reset_n),
    .i_load   (w_load),
    .i_val    (w_val),
    .o_expire (w_expire)
  );

  // state register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_entered <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_entered <= w_load;
    end
  end

  // next state and phase timer reload
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_val    = '0;
    w_accept = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = ST_A_SETUP;
          w_load   = 1'b1;
          w_val    = LD_SETUP;
        end
      end
      ST_A_SETUP: begin
        if (w_expire) begin
          w_next = ST_A_STROBE;
          w_load = 1'b1;
          w_val  = LD_PULSE;
        end
      end
      ST_A_STROBE: begin
        if (w_expire) begin
          w_next = ST_A_HOLD;
          w_load = 1'b1;
          w_val  = LD_HOLD;
        end
      end
      ST_A_HOLD: begin
        if (w_expire) begin
          w_next = ST_D_SETUP;
          w_load = 1'b1;
          w_val  = LD_SETUP;
        end
      end
      ST_D_SETUP: begin
        if (w_expire) begin
          w_next = ST_D_STROBE;
          w_load = 1'b1;
          w_val  = LD_PULSE;
        end
      end
      ST_D_STROBE: begin
        if (w_expire) begin
          w_next = ST_D_HOLD;
          w_load = 1'b1;
          w_val  = LD_HOLD;
        end
      end
      ST_D_HOLD: begin
        if (w_expire) begin
          w_next = ST_GAP;
          w_load = 1'b1;
          w_val  = LD_GAP;
        end
      end
      ST_GAP: begin
        if (w_expire) begin
          // a held start restarts right after the gap
          if (bus.start) begin
            w_accept = 1'b1;
            w_next   = ST_A_SETUP;
            w_load   = 1'b1;
            w_val    = LD_SETUP;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // operands latched only when a request is taken
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_rw    <= bus.RW;
      r_addr  <= bus.addr;
      r_wdata <= bus.wdata;
    end
  end

  assign w_aph = (r_state == ST_A_SETUP)
              || (r_state == ST_A_STROBE)
              || (r_state == ST_A_HOLD);
  assign w_dph = (r_state == ST_D_SETUP)
              || (r_state == ST_D_STROBE)
              || (r_state == ST_D_HOLD);

  // pin levels decoded from the current state
  always_comb begin
    w_cs_n   = 1'b1;
    w_wr_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_a_d    = 1'b0;
    w_ad_oe  = 1'b0;
    w_ad_out = '0;
    unique case (1'b1)
      w_aph: begin
        w_cs_n   = 1'b0;
        w_ad_oe  = 1'b1;
        w_ad_out = r_addr;
        w_wr_n   = (r_state != ST_A_STROBE);
      end
      w_dph: begin
        w_cs_n = 1'b0;
        w_a_d  = 1'b1;
        if (r_rw) begin
          w_rd_n = (r_state != ST_D_STROBE);
        end else begin
          w_ad_oe  = 1'b1;
          w_ad_out = r_wdata;
          w_wr_n   = (r_state != ST_D_STROBE);
        end
      end
      default: begin
        w_cs_n = 1'b1;
      end
    endcase
  end

  assign w_busy = (r_state != ST_IDLE);
  assign w_done = (r_state == ST_GAP)
               && r_entered;

  // registered pins, status and read data
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cs_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_a_d    <= 1'b0;
      r_ad_oe  <= 1'b0;
      r_ad_out <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_cs_n   <= w_cs_n;
      r_wr_n   <= w_wr_n;
      r_rd_n   <= w_rd_n;
      r_a_d    <= w_a_d;
      r_ad_oe  <= w_ad_oe;
      r_ad_out <= w_ad_out;
      r_busy   <= w_busy;
      r_done   <= w_done;
      if (w_done && r_rw) begin
        r_rdata <= r_cap;
      end
    end
  end

  // sample the pad while rd_n is still low
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cap <= '0;
    end else if ((r_state == ST_D_HOLD)
                 && r_entered && r_rw) begin
      r_cap <= bus.ad_in;
    end
  end

  assign bus.cs_n   = r_cs_n;
  assign bus.wr_n   = r_wr_n;
  assign bus.rd_n   = r_rd_n;
  assign bus.a_d    = r_a_d;
  assign bus.ad_oe  = r_ad_oe;
  assign bus.ad_out = r_ad_out;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.rdata  = r_rdata;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench for rtc_bus_ctrl: default
// timing instance plus an all-ones timing one.
module tb_rtc_bus_ctrl;
  import rtc_pkg::*;

  typedef struct {
    bit         rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;

  int n_vec = 0;
  int n_miss = 0;

  exp_t q0[$];
  exp_t q1[$];

  rtc_bus_ctrl_if bus0 ();
  rtc_bus_ctrl_if bus1 ();

  rtc_bus_ctrl dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus0.slave)
  );

  rtc_bus_ctrl #(
    .T_SETUP (1),
    .T_PULSE (1),
    .T_HOLD  (1),
    .T_GAP   (1)
  ) dut1 (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string nm,
    input int    act,
    input int    req
  );
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, req);
    end
  endtask

  // monitor for the default-timing instance
  bit         m_act = 0;
  bit         m_gd = 0;
  bit         m_pcs = 1;
  bit         m_dset = 0;
  int         m_cyc, m_cs, m_bad, m_dn, m_dc;
  int         m_wf, m_wl, m_wc;
  int         m_rf, m_rl, m_rc;
  logic [7:0] m_oa, m_od;
  logic       m_doe;

  always @(negedge clk) begin
    exp_t e;
    if (!Reset_n) begin
      m_act = 0;
      m_gd  = 0;
      m_pcs = 1;
    end else begin
      if (m_act) m_cyc++;
      if (m_act && m_gd
          && (!bus0.busy
              || (!bus0.cs_n && m_pcs))) begin
        m_act = 0;
        if (q0.size() == 0) begin
          chk("q0_empty_at_end", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("addr", m_oa, e.addr);
          chk("data_oe", m_doe, !e.rw);
          if (!e.rw) chk("wdata", m_od, e.wdata);
          chk("wr_first", m_wf, 3);
          chk("wr_last", m_wl, e.rw ? 10 : 22);
          chk("wr_cnt", m_wc, e.rw ? 8 : 16);
          chk("rd_first", m_rf, e.rw ? 15 : 0);
          chk("rd_last", m_rl, e.rw ? 22 : 0);
          chk("rd_cnt", m_rc, e.rw ? 8 : 0);
          chk("cs_len", m_cs, 24);
          chk("done_cyc", m_dc, 25);
          chk("done_cnt", m_dn, 1);
          chk("end_cyc", m_cyc, 29);
          chk("rdata", bus0.rdata, e.rdata);
          chk("pin_rules", m_bad, 0);
        end
      end
      if (!m_act && !bus0.cs_n && m_pcs) begin
        m_act = 1;  m_gd = 0;  m_dset = 0;
        m_cyc = 1;  m_cs = 0;  m_bad = 0;
        m_dn = 0;   m_dc = 0;
        m_wf = 0;   m_wl = 0;  m_wc = 0;
        m_rf = 0;   m_rl = 0;  m_rc = 0;
        m_oa = bus0.ad_out;
        m_od = '0;  m_doe = 0;
      end
      if (m_act) begin
        if (!bus0.cs_n) m_cs++;
        if (!bus0.cs_n && !bus0.a_d) begin
          if (bus0.ad_out != m_oa) m_bad++;
          if (!bus0.ad_oe) m_bad++;
        end
        if (!bus0.cs_n && bus0.a_d) begin
          if (!m_dset) begin
            m_dset = 1;
            m_od  = bus0.ad_out;
            m_doe = bus0.ad_oe;
          end else if (bus0.ad_oe != m_doe
                       || bus0.ad_out != m_od) begin
            m_bad++;
          end
        end
        if (!bus0.wr_n) begin
          if (m_wc == 0) m_wf = m_cyc;
          m_wl = m_cyc;
          m_wc++;
        end
        if (!bus0.rd_n) begin
          if (m_rc == 0) m_rf = m_cyc;
          m_rl = m_cyc;
          m_rc++;
        end
        if (!bus0.wr_n && !bus0.rd_n) m_bad++;
        if (bus0.cs_n
            && (!bus0.wr_n || !bus0.rd_n)) m_bad++;
        if (!bus0.busy) m_bad++;
        if (bus0.done) begin
          m_dn++;
          m_dc = m_cyc;
          m_gd = 1;
        end
      end else if (bus0.done) begin
        chk("stray_done", 1, 0);
      end
      m_pcs = bus0.cs_n;
    end
  end

  // monitor for the all-ones timing instance
  bit         s_pb = 0;
  bit         s_pw = 1;
  bit         s_pr = 1;
  int         s_busy = 0, s_cs = 0, s_dn = 0;
  int         s_wc = 0, s_rc = 0, s_run = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!Reset_n) begin
      s_pb = 0;  s_busy = 0;  s_cs = 0;
      s_dn = 0;  s_wc = 0;  s_rc = 0;
      s_run = 0; s_pw = 1;  s_pr = 1;
    end else begin
      if (s_pb && !bus1.busy) begin
        if (q1.size() == 0) begin
          chk("q1_empty_at_end", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("t1_busy_len", s_busy, 7);
          chk("t1_cs_len", s_cs, 6);
          chk("t1_wr_cnt", s_wc, e.rw ? 1 : 2);
          chk("t1_rd_cnt", s_rc, e.rw ? 1 : 0);
          chk("t1_done_cnt", s_dn, 1);
          chk("t1_strobe_run", s_run, 0);
          chk("t1_rdata", bus1.rdata, e.rdata);
        end
        s_busy = 0; s_cs = 0; s_dn = 0;
        s_wc = 0;   s_rc = 0; s_run = 0;
      end
      if (bus1.busy) s_busy++;
      if (!bus1.cs_n) s_cs++;
      if (!bus1.wr_n) s_wc++;
      if (!bus1.rd_n) s_rc++;
      if (!bus1.wr_n && !s_pw) s_run++;
      if (!bus1.rd_n && !s_pr) s_run++;
      if (bus1.done) s_dn++;
      s_pb = bus1.busy;
      s_pw = bus1.wr_n;
      s_pr = bus1.rd_n;
    end
  end

  task automatic wait_idle(input bit sel);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel ? !bus1.busy : !bus0.busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic issue(
    input bit         sel,
    input bit         push,
    input bit         rw,
    input logic [7:0] a,
    input logic [7:0] d,
    input logic [7:0] rexp
  );
    exp_t e;
    e.rw = rw;  e.addr = a;
    e.wdata = d; e.rdata = rexp;
    if (push) begin
      if (sel) q1.push_back(e);
      else q0.push_back(e);
    end
    if (sel) begin
      bus1.RW = rw; bus1.addr = a;
      bus1.wdata = d; bus1.start = 1;
      @(negedge clk);
      bus1.start = 0;
    end else begin
      bus0.RW = rw; bus0.addr = a;
      bus0.wdata = d; bus0.start = 1;
      @(negedge clk);
      bus0.start = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.start = 0; bus0.RW = 0;
    bus0.addr = 0;  bus0.wdata = 0;
    bus0.ad_in = 0;
    bus1.start = 0; bus1.RW = 0;
    bus1.addr = 0;  bus1.wdata = 0;
    bus1.ad_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus0.cs_n, 1);
    chk("rst_wr_n", bus0.wr_n, 1);
    chk("rst_rd_n", bus0.rd_n, 1);
    chk("rst_a_d", bus0.a_d, 0);
    chk("rst_ad_oe", bus0.ad_oe, 0);
    chk("rst_ad_out", bus0.ad_out, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_rdata", bus0.rdata, 0);
    #2 Reset_n = 1;
    @(negedge clk);

    issue(0, 1, 0, RTC_ADDR_SEC, 8'h45, 8'h00);
    wait_idle(0);
    bus0.ad_in = 8'h37;
    issue(0, 1, 1, RTC_ADDR_MIN, 8'h00, 8'h37);
    wait_idle(0);
    bus0.ad_in = 8'h00;
    issue(0, 1, 0, RTC_ADDR_HOUR, 8'h10, 8'h37);
    wait_idle(0);

    issue(0, 1, 0, RTC_ADDR_SEC, 8'h59, 8'h37);
    repeat (4) @(negedge clk);
    bus0.RW = 1; bus0.addr = 8'h99;
    bus0.wdata = 8'hAA; bus0.start = 1;
    @(negedge clk);
    bus0.start = 0;
    wait_idle(0);

    q0.push_back('{0, 8'h22, 8'h11, 8'h37});
    q0.push_back('{0, 8'h23, 8'h66, 8'h37});
    bus0.RW = 0; bus0.addr = 8'h22;
    bus0.wdata = 8'h11; bus0.start = 1;
    repeat (2) @(negedge clk);
    bus0.addr = 8'h23; bus0.wdata = 8'h66;
    repeat (30) @(negedge clk);
    bus0.start = 0;
    wait_idle(0);

    issue(0, 0, 0, RTC_ADDR_SEC, 8'h77, 8'h00);
    repeat (17) @(negedge clk);
    chk("abort_mid_strobe", bus0.wr_n, 0);
    #2 Reset_n = 0;
    #1;
    chk("abort_cs_n", bus0.cs_n, 1);
    chk("abort_wr_n", bus0.wr_n, 1);
    chk("abort_rd_n", bus0.rd_n, 1);
    chk("abort_ad_oe", bus0.ad_oe, 0);
    chk("abort_busy", bus0.busy, 0);
    repeat (2) @(negedge clk);
    #2 Reset_n = 1;
    @(negedge clk);
    bus0.ad_in = 8'h12;
    issue(0, 1, 1, RTC_ADDR_HOUR, 8'h00, 8'h12);
    wait_idle(0);

    issue(1, 1, 0, RTC_ADDR_SEC, 8'h33, 8'h00);
    wait_idle(1);
    bus1.ad_in = 8'h5A;
    issue(1, 1, 1, RTC_ADDR_MIN, 8'h00, 8'h5A);
    wait_idle(1);

    repeat (5) @(negedge clk);
    chk("q0_left", q0.size(), 0);
    chk("q1_left", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
